// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM writer and readback blocks: word-index
// geometry, sweep state encoding and the per-bank expected-data selector.
package jtsdram_pkg;

   localparam int WORD_W = 24;   // {ba[1:0], addr[21:0]}
   localparam int ADDR_W = 22;
   localparam int BA_W   = 2;
   localparam int DATA_W = 16;
   localparam int CNT_W  = 16;

   typedef logic [WORD_W-1:0] word_idx_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_CMP  = 2'd2,
      ST_FIN  = 2'd3
   } sweep_state_t;

   // Picks the expected word of the bank currently being addressed.
   function automatic logic [DATA_W-1:0] bank_sel(
      input logic [BA_W-1:0]   ba,
      input logic [DATA_W-1:0] d0,
      input logic [DATA_W-1:0] d1,
      input logic [DATA_W-1:0] d2,
      input logic [DATA_W-1:0] d3
   );
      case (ba)
         2'd0:    bank_sel = d0;
         2'd1:    bank_sel = d1;
         2'd2:    bank_sel = d2;
         default: bank_sel = d3;
      endcase
   endfunction

endpackage

// File: rtl/jtsdram_cmp.sv
// Readback comparator: captures the expected and the read word, flags a
// mismatch, counts mismatches (saturating) and remembers the first bad word.
module jtsdram_cmp
   import jtsdram_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clr,      // start of a new sweep
   input  logic              i_req,      // FSM is in REQ
   input  logic              i_ack,      // accepted read acknowledge
   input  logic              i_cmp,      // FSM is in CMP
   input  word_idx_t         i_word,
   input  logic [BA_W-1:0]   i_ba,
   input  logic [DATA_W-1:0] i_ba0_data,
   input  logic [DATA_W-1:0] i_ba1_data,
   input  logic [DATA_W-1:0] i_ba2_data,
   input  logic [DATA_W-1:0] i_ba3_data,
   input  logic [DATA_W-1:0] i_dout,
   output logic              o_mismatch,
   output logic              o_error,
   output logic [CNT_W-1:0]  o_err_cnt,
   output word_idx_t         o_first_err
);

   logic [DATA_W-1:0] r_exp;
   logic [DATA_W-1:0] r_rd;
   logic              r_error;
   logic [CNT_W-1:0]  r_err_cnt;
   word_idx_t         r_first_err;
   logic [DATA_W-1:0] w_exp;

   assign w_exp       = bank_sel(i_ba, i_ba0_data, i_ba1_data, i_ba2_data, i_ba3_data);
   assign o_mismatch  = (r_rd != r_exp);
   assign o_error     = r_error;
   assign o_err_cnt   = r_err_cnt;
   assign o_first_err = r_first_err;

   // Capture the expected word every REQ cycle (the last one, on the ack cycle,
   // is what CMP sees) and the SDRAM word on the accepted acknowledge.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp <= '0;
         r_rd  <= '0;
      end else begin
         if (i_req) r_exp <= w_exp;
         if (i_ack) r_rd  <= i_dout;
      end
   end

   // Error bookkeeping: sticky flag, saturating count, first failing index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_error     <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else if (i_clr) begin
         r_error     <= 1'b0;
         r_err_cnt   <= '0;
         r_first_err <= '0;
      end else if (i_cmp && o_mismatch) begin
         r_error <= 1'b1;
         if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
         if (!r_error) r_first_err <= i_word;
      end
   end

endmodule

// File: rtl/jtsdram_readback.sv
// SDRAM readback checker: sweeps word indices 0..LAST_WORD, reads each word
// and compares it against the per-bank expected data.
module jtsdram_readback
   import jtsdram_pkg::*;
#(
   parameter bit        STOP_ON_ERR = 1'b0,
   parameter word_idx_t LAST_WORD   = 24'hFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  err_cnt,
   output word_idx_t         first_err,
   input  logic [DATA_W-1:0] ba0_data,
   input  logic [DATA_W-1:0] ba1_data,
   input  logic [DATA_W-1:0] ba2_data,
   input  logic [DATA_W-1:0] ba3_data,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [BA_W-1:0]   prog_ba,
   output logic              prog_rd,
   output logic              prog_we,
   output logic [1:0]        prog_mask,
   input  logic [DATA_W-1:0] prog_dout,
   input  logic              prog_rdy
);

   sweep_state_t r_state;
   word_idx_t    r_word;
   logic         r_prog_rd;
   logic         r_busy;
   logic         r_done;
   logic         w_req;
   logic         w_ack;
   logic         w_cmp;
   logic         w_mismatch;

   assign w_req = (r_state == ST_REQ);
   // Only an acknowledge to a read actually on the bus counts; stray or stale
   // acknowledges (e.g. from an aborted read) are dropped.
   assign w_ack = w_req && r_prog_rd && prog_rdy;
   assign w_cmp = (r_state == ST_CMP);

   assign prog_ba   = r_word[WORD_W-1 -: BA_W];
   assign prog_addr = r_word[ADDR_W-1:0];
   assign prog_rd   = r_prog_rd;
   assign prog_we   = 1'b0;
   assign prog_mask = 2'b00;
   assign busy      = r_busy;
   assign done      = r_done;

   // Sweep FSM with the word counter and registered handshake/status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_word    <= '0;
         r_prog_rd <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else if (start) begin
         // Restart from any state; prog_rd stays low for one REQ cycle.
         r_state   <= ST_REQ;
         r_word    <= '0;
         r_prog_rd <= 1'b0;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: ;
            ST_REQ: begin
               if (w_ack) begin
                  r_prog_rd <= 1'b0;
                  r_state   <= ST_CMP;
               end else begin
                  r_prog_rd <= 1'b1;
               end
            end
            ST_CMP: begin
               if (STOP_ON_ERR && w_mismatch) begin
                  r_state <= ST_FIN;
               end else if (r_word == LAST_WORD) begin
                  r_state <= ST_FIN;
               end else begin
                  r_word    <= r_word + 1'b1;   // addr carry rolls into ba
                  r_prog_rd <= 1'b1;
                  r_state   <= ST_REQ;
               end
            end
            ST_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   jtsdram_cmp u_cmp (
      .clk         (clk),
      .rst         (rst),
      .i_clr       (start),
      .i_req       (w_req),
      .i_ack       (w_ack),
      .i_cmp       (w_cmp),
      .i_word      (r_word),
      .i_ba        (prog_ba),
      .i_ba0_data  (ba0_data),
      .i_ba1_data  (ba1_data),
      .i_ba2_data  (ba2_data),
      .i_ba3_data  (ba3_data),
      .i_dout      (prog_dout),
      .o_mismatch  (w_mismatch),
      .o_error     (error),
      .o_err_cnt   (err_cnt),
      .o_first_err (first_err)
   );

endmodule

// File: tb/tb_jtsdram_readback.sv
// Directed bench for jtsdram_readback. Three instances cover the parameter
// sets: [0] full check, LAST_WORD=15; [1] STOP_ON_ERR=1, LAST_WORD=15;
// [2] LAST_WORD=24'h40_0001 for the bank crossing. Each has an SDRAM model
// that answers prog_rd after 'lat' cycles with a pattern, optionally flipped.
module tb_jtsdram_readback;

   localparam logic [2:0]  SE = 3'b010;
   localparam logic [71:0] LW = {24'h40_0001, 24'd15, 24'd15};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] start_v = 3'b000;
   logic [2:0] done_v;
   logic [2:0] rd_v;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] pat(input logic [23:0] w);
      return (w[15:0] ^ 16'h5A3C) + {w[23:16], 8'h00};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic        busy, done, error, prog_rd, prog_we;
      logic        prog_rdy = 1'b0;
      logic [15:0] err_cnt, ba0_data, ba1_data, ba2_data, ba3_data;
      logic [15:0] prog_dout = 16'h0000;
      logic [23:0] first_err;
      logic [21:0] prog_addr;
      logic [1:0]  prog_ba, prog_mask;
      // model configuration, written only by the test tasks
      int          lat;
      bit          hold_all;
      logic [23:0] hold_w;
      logic [15:0] corr;
      bit          corr_all;
      // model state, written only by the responder below
      int          cnt = 0;
      int          n_reads = 0;
      int          since = 0;
      int          gap = 0;
      bit          prev_rd = 1'b0;
      logic [23:0] rd_log [256];

      assign ba0_data  = pat({2'd0, prog_addr});
      assign ba1_data  = pat({2'd1, prog_addr});
      assign ba2_data  = pat({2'd2, prog_addr});
      assign ba3_data  = pat({2'd3, prog_addr});
      assign done_v[g] = done;
      assign rd_v[g]   = prog_rd;

      jtsdram_readback #(.STOP_ON_ERR(SE[g]), .LAST_WORD(LW[g*24 +: 24])) u_dut (
         .clk(clk), .rst(rst), .start(start_v[g]), .busy(busy), .done(done),
         .error(error), .err_cnt(err_cnt), .first_err(first_err),
         .ba0_data(ba0_data), .ba1_data(ba1_data), .ba2_data(ba2_data), .ba3_data(ba3_data),
         .prog_addr(prog_addr), .prog_ba(prog_ba), .prog_rd(prog_rd), .prog_we(prog_we),
         .prog_mask(prog_mask), .prog_dout(prog_dout), .prog_rdy(prog_rdy)
      );

      // SDRAM model: one-cycle ack after 'lat' cycles of prog_rd, logs reads,
      // and measures ack -> next prog_rd rise in negedges.
      always @(negedge clk) begin
         logic [23:0] w;
         w = {prog_ba, prog_addr};
         since = since + 1;
         if (prog_rd && !prev_rd) gap = since;
         prev_rd = prog_rd;
         if (rst) begin
            prog_rdy = 1'b0;
            cnt = 0;
         end else if (prog_rdy) begin
            prog_rdy = 1'b0;
         end else if (prog_rd && !hold_all && w != hold_w) begin
            cnt = cnt + 1;
            if (cnt >= lat) begin
               cnt = 0;
               prog_dout = pat(w) ^ ((corr_all || (w < 24'd16 && corr[w[3:0]])) ? 16'h0001 : 16'h0000);
               prog_rdy = 1'b1;
               since = 0;
               rd_log[n_reads & 255] = w;
               n_reads = n_reads + 1;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   task automatic pulse(input int g);
      @(negedge clk);
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
   endtask

   task automatic wait_done(input int g, input int budget);
      for (int i = 0; i < budget && done_v[g] !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic wait_rd(input int g, input int budget);
      for (int i = 0; i < budget && rd_v[g] !== 1'b1; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++; if ({g_dut[0].busy, g_dut[0].done, g_dut[0].error} !== 3'b000) begin
         $display("FAIL reset_status: got busy/done/error=%b want 000", {g_dut[0].busy, g_dut[0].done, g_dut[0].error}); errors++; end
      checks++; if (g_dut[0].err_cnt !== 16'h0000) begin
         $display("FAIL reset_err_cnt: got %h want 0000", g_dut[0].err_cnt); errors++; end
      checks++; if (g_dut[0].first_err !== 24'h0) begin
         $display("FAIL reset_first_err: got %h want 000000", g_dut[0].first_err); errors++; end
      checks++; if ({g_dut[0].prog_rd, g_dut[0].prog_we, g_dut[0].prog_mask} !== 4'b0000) begin
         $display("FAIL reset_prog: got rd/we/mask=%b want 0000", {g_dut[0].prog_rd, g_dut[0].prog_we, g_dut[0].prog_mask}); errors++; end
      checks++; if ({g_dut[0].prog_ba, g_dut[0].prog_addr} !== 24'h0) begin
         $display("FAIL reset_addr: got %h want 000000", {g_dut[0].prog_ba, g_dut[0].prog_addr}); errors++; end
   endtask

   task automatic test_match();
      int n0, bad;
      g_dut[0].lat = 3; g_dut[0].corr = 16'h0000; g_dut[0].corr_all = 1'b0;
      n0 = g_dut[0].n_reads;
      pulse(0);
      checks++; if (g_dut[0].busy !== 1'b1) begin
         $display("FAIL match_busy: got %b want 1", g_dut[0].busy); errors++; end
      wait_done(0, 2000);
      checks++; if ({g_dut[0].done, g_dut[0].busy, g_dut[0].error} !== 3'b100) begin
         $display("FAIL match_status: got done/busy/error=%b want 100", {g_dut[0].done, g_dut[0].busy, g_dut[0].error}); errors++; end
      checks++; if (g_dut[0].err_cnt !== 16'h0000) begin
         $display("FAIL match_err_cnt: got %h want 0000", g_dut[0].err_cnt); errors++; end
      checks++; if (g_dut[0].n_reads - n0 !== 16) begin
         $display("FAIL match_reads: got %0d want 16", g_dut[0].n_reads - n0); errors++; end
      bad = 0;
      for (int i = 0; i < 16; i++) if (g_dut[0].rd_log[(n0 + i) & 255] !== 24'(i)) bad++;
      checks++; if (bad !== 0) begin
         $display("FAIL match_addr_seq: got %0d out-of-order reads want 0", bad); errors++; end
      checks++; if (g_dut[0].gap !== 2) begin
         $display("FAIL match_latency: got %0d cycles want 2", g_dut[0].gap); errors++; end
      repeat (3) @(negedge clk);
      checks++; if (g_dut[0].done !== 1'b1) begin
         $display("FAIL match_done_held: got %b want 1", g_dut[0].done); errors++; end
   endtask

   task automatic test_corrupt();
      g_dut[0].lat = 2; g_dut[0].corr = 16'h0220;   // words 5 and 9
      pulse(0);
      wait_done(0, 2000);
      checks++; if ({g_dut[0].done, g_dut[0].error} !== 2'b11) begin
         $display("FAIL corrupt_status: got done/error=%b want 11", {g_dut[0].done, g_dut[0].error}); errors++; end
      checks++; if (g_dut[0].err_cnt !== 16'd2) begin
         $display("FAIL corrupt_err_cnt: got %0d want 2", g_dut[0].err_cnt); errors++; end
      checks++; if (g_dut[0].first_err !== 24'd5) begin
         $display("FAIL corrupt_first_err: got %h want 000005", g_dut[0].first_err); errors++; end
      g_dut[0].corr = 16'h0000;
   endtask

   task automatic test_stop();
      int n0;
      g_dut[1].lat = 1; g_dut[1].corr = 16'h0020;   // word 5
      n0 = g_dut[1].n_reads;
      pulse(1);
      wait_done(1, 2000);
      checks++; if ({g_dut[1].done, g_dut[1].error} !== 2'b11) begin
         $display("FAIL stop_status: got done/error=%b want 11", {g_dut[1].done, g_dut[1].error}); errors++; end
      checks++; if (g_dut[1].n_reads - n0 !== 6) begin
         $display("FAIL stop_reads: got %0d want 6", g_dut[1].n_reads - n0); errors++; end
      checks++; if (g_dut[1].first_err !== 24'd5) begin
         $display("FAIL stop_first_err: got %h want 000005", g_dut[1].first_err); errors++; end
      checks++; if (g_dut[1].err_cnt !== 16'd1) begin
         $display("FAIL stop_err_cnt: got %0d want 1", g_dut[1].err_cnt); errors++; end
   endtask

   task automatic test_bank_cross();
      int n0;
      g_dut[2].lat = 2; g_dut[2].hold_all = 1'b1;
      n0 = g_dut[2].n_reads;
      pulse(2);
      wait_rd(2, 50);
      // Jump the counter close to the bank boundary instead of sweeping 4M words.
      force g_dut[2].u_dut.r_word = 24'h3F_FFFE;
      @(negedge clk);
      release g_dut[2].u_dut.r_word;
      g_dut[2].hold_all = 1'b0;
      wait_done(2, 500);
      checks++; if ({g_dut[2].done, g_dut[2].error} !== 2'b10) begin
         $display("FAIL bank_status: got done/error=%b want 10", {g_dut[2].done, g_dut[2].error}); errors++; end
      checks++; if (g_dut[2].n_reads - n0 !== 4) begin
         $display("FAIL bank_reads: got %0d want 4", g_dut[2].n_reads - n0); errors++; end
      checks++; if (g_dut[2].rd_log[(n0 + 1) & 255] !== 24'h3F_FFFF) begin
         $display("FAIL bank_last_ba0: got %h want 3fffff", g_dut[2].rd_log[(n0 + 1) & 255]); errors++; end
      checks++; if (g_dut[2].rd_log[(n0 + 2) & 255] !== 24'h40_0000) begin
         $display("FAIL bank_wrap: got %h want 400000", g_dut[2].rd_log[(n0 + 2) & 255]); errors++; end
      checks++; if ({g_dut[2].prog_ba, g_dut[2].prog_addr} !== {2'd1, 22'd1}) begin
         $display("FAIL bank_final_addr: got ba=%0d addr=%h want ba=1 addr=000001", g_dut[2].prog_ba, g_dut[2].prog_addr); errors++; end
   endtask

   task automatic test_restart();
      int n1;
      g_dut[0].lat = 3; g_dut[0].corr = 16'h0004; g_dut[0].hold_w = 24'd7;
      pulse(0);
      for (int i = 0; i < 500 && !(g_dut[0].prog_rd === 1'b1 && g_dut[0].prog_addr === 22'd7); i++) @(negedge clk);
      checks++; if (g_dut[0].err_cnt !== 16'd1) begin
         $display("FAIL restart_pre_err_cnt: got %0d want 1", g_dut[0].err_cnt); errors++; end
      n1 = g_dut[0].n_reads;
      pulse(0);
      g_dut[0].hold_w = 24'hFF_FFFF;
      checks++; if (g_dut[0].prog_rd !== 1'b0) begin
         $display("FAIL restart_rd_drop: got %b want 0", g_dut[0].prog_rd); errors++; end
      checks++; if ({g_dut[0].error, g_dut[0].err_cnt, g_dut[0].first_err} !== 41'h0) begin
         $display("FAIL restart_cleared: got error=%b cnt=%h first=%h want 0", g_dut[0].error, g_dut[0].err_cnt, g_dut[0].first_err); errors++; end
      for (int i = 0; i < 100 && g_dut[0].n_reads == n1; i++) @(negedge clk);
      checks++; if (g_dut[0].rd_log[n1 & 255] !== 24'd0) begin
         $display("FAIL restart_first_read: got %h want 000000", g_dut[0].rd_log[n1 & 255]); errors++; end
      wait_done(0, 2000);
      checks++; if ({g_dut[0].done, g_dut[0].err_cnt, g_dut[0].first_err} !== {1'b1, 16'd1, 24'd2}) begin
         $display("FAIL restart_end: got done=%b cnt=%0d first=%h want 1/1/000002", g_dut[0].done, g_dut[0].err_cnt, g_dut[0].first_err); errors++; end
      g_dut[0].corr = 16'h0000;
   endtask

   task automatic test_saturate();
      g_dut[0].lat = 1; g_dut[0].corr_all = 1'b1;
      pulse(0);
      // Preload the count close to the top; the remaining mismatches stand in
      // for the tens of thousands needed to get there from zero.
      force g_dut[0].u_dut.u_cmp.r_err_cnt = 16'hFFF8;
      @(negedge clk);
      release g_dut[0].u_dut.u_cmp.r_err_cnt;
      wait_done(0, 2000);
      checks++; if (g_dut[0].err_cnt !== 16'hFFFF) begin
         $display("FAIL sat_err_cnt: got %h want ffff", g_dut[0].err_cnt); errors++; end
      checks++; if ({g_dut[0].done, g_dut[0].error, g_dut[0].first_err} !== {2'b11, 24'd0}) begin
         $display("FAIL sat_status: got done=%b error=%b first=%h want 1/1/000000", g_dut[0].done, g_dut[0].error, g_dut[0].first_err); errors++; end
      g_dut[0].corr_all = 1'b0;
   endtask

   task automatic test_reset_mid();
      g_dut[0].hold_all = 1'b1;
      pulse(0);
      wait_rd(0, 50);
      #2 rst = 1'b1;
      #1;
      checks++; if ({g_dut[0].prog_rd, g_dut[0].busy} !== 2'b00) begin
         $display("FAIL rstmid_immediate: got rd/busy=%b want 00", {g_dut[0].prog_rd, g_dut[0].busy}); errors++; end
      @(negedge clk);
      rst = 1'b0;
      g_dut[0].hold_all = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({g_dut[0].prog_rd, g_dut[0].busy, g_dut[0].done, g_dut[0].error, g_dut[0].err_cnt} !== 20'h0) begin
         $display("FAIL rstmid_idle: got rd/busy/done/error=%b cnt=%h want 0", {g_dut[0].prog_rd, g_dut[0].busy, g_dut[0].done, g_dut[0].error}, g_dut[0].err_cnt); errors++; end
   endtask

   initial begin
      g_dut[0].lat = 3; g_dut[0].hold_all = 1'b0; g_dut[0].hold_w = 24'hFF_FFFF; g_dut[0].corr = '0; g_dut[0].corr_all = 1'b0;
      g_dut[1].lat = 3; g_dut[1].hold_all = 1'b0; g_dut[1].hold_w = 24'hFF_FFFF; g_dut[1].corr = '0; g_dut[1].corr_all = 1'b0;
      g_dut[2].lat = 3; g_dut[2].hold_all = 1'b0; g_dut[2].hold_w = 24'hFF_FFFF; g_dut[2].corr = '0; g_dut[2].corr_all = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_match();
      test_corrupt();
      test_stop();
      test_bank_cross();
      test_restart();
      test_saturate();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish within 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/jtsdram_readback.md
JTSDRAM_READBACK -- requirements
Module: jtsdram_readback

Interface
REQ-001 Parameter STOP_ON_ERR, default 0: when 1, the sweep ends at the first mismatch.
REQ-002 Parameter LAST_WORD, default 24'hFF_FFFF: final word index {ba,addr} of the sweep; a smaller value shortens simulation.
REQ-003 clk  in  1  clock; reset rst, asynchronous, active-high.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  single-cycle pulse that begins or restarts a readback sweep.
REQ-006 busy  out  1  high while a sweep is in progress.
REQ-007 done  out  1  high after a sweep completes; held until the next start.
REQ-008 error  out  1  sticky flag: at least one mismatch occurred in this sweep.
REQ-009 err_cnt  out  16  number of mismatches in this sweep, saturating.
REQ-010 first_err  out  24  {ba,addr} of the first mismatching word.
REQ-011 ba0_data..ba3_data  in  16 each  expected word for the current address, one input per bank.
REQ-012 prog_addr  out  22  SDRAM word address.
REQ-013 prog_ba  out  2  SDRAM bank.
REQ-014 prog_rd  out  1  read request.
REQ-015 prog_we  out  1  tied to 0.
REQ-016 prog_mask  out  2  tied to 2'b00 (full word).
REQ-017 prog_dout  in  16  read data from SDRAM.
REQ-018 prog_rdy  in  1  read acknowledge; prog_dout is valid in the same cycle.

Function
REQ-019 The module SHALL implement the states IDLE, REQ, CMP and FIN.
REQ-020 IDLE transitions:
  - start -> REQ.
  - word counter cleared to 0.
  - error, err_cnt and first_err cleared.
  - busy set to 1; done set to 0.
REQ-021 REQ behaviour:
  - prog_rd is 1 and {prog_ba,prog_addr} equals the word counter.
  - Both are held stable until prog_rdy.
REQ-022 Expected-data capture in REQ:
  - The expected word is selected from ba0..ba3_data by prog_ba.
  - It is registered on every REQ cycle; the value from the prog_rdy cycle is the one used.
REQ-023 On prog_rdy in REQ:
  - prog_dout is registered.
  - prog_rd drops to 0 the next cycle.
  - The FSM goes to CMP.
REQ-024 CMP lasts exactly 1 cycle and compares the registered read word against the registered expected word.
REQ-025 On a mismatch in CMP:
  - error is set.
  - err_cnt increments, saturating at 16'hFFFF.
  - first_err is loaded with the word counter only if error was previously 0.
REQ-026 CMP exit, evaluated in this order:
  - STOP_ON_ERR=1 and a mismatch -> FIN.
  - Word counter equals LAST_WORD -> FIN.
  - Otherwise the counter increments by 1 and the FSM returns to REQ.
REQ-027 The word counter SHALL be 24 bits: {ba[1:0], addr[21:0]}; a carry out of addr rolls into ba.
REQ-028 FIN SHALL set busy=0 and done=1, then go to IDLE with done held.
REQ-029 start in any state SHALL abort the current sweep and restart it as in REQ-020; prog_rd drops for 1 cycle before the new request.
REQ-030 prog_rdy outside REQ SHALL be ignored.
REQ-031 Per-word latency from prog_rdy to the next prog_rd SHALL be 2 cycles.

Reset
REQ-032 rst SHALL force:
  - State IDLE; counter 0.
  - prog_rd=0, busy=0, done=0, error=0, err_cnt=0, first_err=0.
  - Captured data registers 0.
REQ-033 Reset asserted mid-sweep SHALL abandon the outstanding read without waiting for prog_rdy.

Structure
REQ-034 State encodings and the 24-bit word-index width SHALL live in the shared jtsdram package, shared with the writer.
REQ-035 A sub-module jtsdram_cmp SHALL hold:
  - the expected/read capture registers;
  - the mismatch detection;
  - the saturating counter;
  - first_err.
  The FSM and address counter remain in the top module.

Verification
REQ-036 Case: LAST_WORD=15, SDRAM model returns a matching pattern, prog_rdy after 3 cycles.
  Required: done=1, error=0, err_cnt=0, and 16 reads issued at addresses 0..15.
REQ-037 Case: LAST_WORD=15, words 5 and 9 corrupted (XOR 16'h0001).
  Required: err_cnt=2, first_err=5, error=1.
REQ-038 Case: STOP_ON_ERR=1, word 5 corrupted.
  Required: done after word 5, exactly 6 reads issued, first_err=5.
REQ-039 Case: LAST_WORD=24'h40_0001, sweep across the bank boundary.
  Required: prog_ba goes 0->1 and prog_addr wraps to 0 at word 24'h40_0000.
REQ-040 Case: start pulsed while waiting for prog_rdy on word 7.
  Required: counters cleared and the next read is at address 0.
  Also: rst asserted mid-REQ gives prog_rd=0 immediately.
REQ-041 Case: forced 70000 mismatches.
  Required: err_cnt saturates at 16'hFFFF.
